// File: rtl/execute_ctrl_pkg.sv
// execute_ctrl_pkg: shared opcode, state, load/store and control-word types for the execute controller.
package execute_ctrl_pkg;
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } rvga_opcode_e;
  typedef enum logic [1:0] {EX_RUN, EX_HOLD, EX_SQUASH} rvga_ex_state_e;
  typedef enum logic [1:0] {LDST_NONE = 2'b00, LDST_LOAD = 2'b01, LDST_STORE = 2'b10} rvga_ldst_e;
  typedef struct packed {
    logic       amux_sel;
    logic       bmux_sel;
    logic [2:0] op;
    logic       alt;
    logic       ldst_v;
  } rvga_execute_cword_t;
  localparam logic [2:0] F3_SR = 3'b101;
  function automatic logic writes_rd(logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_JAL, OPC_JALR};
  endfunction
  function automatic rvga_ldst_e ldst_of(logic [6:0] opc);
    return opc == OPC_LOAD ? LDST_LOAD : opc == OPC_STORE ? LDST_STORE : LDST_NONE;
  endfunction
endpackage

// File: rtl/execute_decode.sv
// execute_decode: combinational opcode to datapath control-word translation.
module execute_decode
  import execute_ctrl_pkg::*;
(
  input  logic                v_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic                alt_i,
  output rvga_execute_cword_t cword_o
);
  always_comb begin
    cword_o = '0;
    if (v_i) begin
      case (opcode_i)
        OPC_OP:     cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b0, op: funct3_i, alt: alt_i, ldst_v: 1'b0};
        OPC_OP_IMM: cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b1, op: funct3_i, alt: (funct3_i == F3_SR) & alt_i, ldst_v: 1'b0};
        OPC_LUI:    cword_o = '{amux_sel: 1'b1, bmux_sel: 1'b1, op: 3'b000, alt: 1'b0, ldst_v: 1'b0};
        // decode has already placed the PC in the rs1 slot
        OPC_AUIPC:  cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b1, op: 3'b000, alt: 1'b0, ldst_v: 1'b0};
        OPC_LOAD,
        OPC_STORE:  cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b1, op: funct3_i, alt: 1'b0, ldst_v: 1'b1};
        OPC_BRANCH: cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b0, op: funct3_i, alt: 1'b0, ldst_v: 1'b0};
        OPC_JALR:   cword_o = '{amux_sel: 1'b0, bmux_sel: 1'b1, op: 3'b000, alt: 1'b0, ldst_v: 1'b1};
        OPC_JAL:    cword_o = '{amux_sel: 1'b1, bmux_sel: 1'b1, op: 3'b000, alt: 1'b0, ldst_v: 1'b0};
        default:    cword_o = '0;
      endcase
    end
  end
endmodule

// File: rtl/execute_ctrl.sv
// execute_ctrl: sequences the execute datapath, registers results and issues branch/jump redirects.
module execute_ctrl
  import execute_ctrl_pkg::*;
#(
  parameter logic [31:0] pc_reset_p = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        id_v_i,
  output logic        id_ready_o,
  input  logic [6:0]  id_opcode_i,
  input  logic [2:0]  id_funct3_i,
  input  logic        id_alt_i,
  input  logic [4:0]  id_rd_i,
  input  logic [31:0] id_pc_i,
  output logic        amux_sel_o,
  output logic        bmux_sel_o,
  output logic [2:0]  op_o,
  output logic        alu_alt_o,
  output logic        alu_ldst_v_o,
  input  logic [31:0] alu_result_i,
  input  logic        bru_result_i,
  output logic        ex_v_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_result_o,
  output logic [4:0]  ex_rd_o,
  output logic [1:0]  ex_ldst_o,
  output logic        redirect_v_o,
  output logic [31:0] redirect_pc_o,
  output logic        squash_o
);
  rvga_execute_cword_t cword;
  rvga_ex_state_e      state_q, state_d;
  logic        ex_v_q, ex_v_d, redirect_v_q, redirect_v_d, squash_q, squash_d;
  logic [31:0] ex_result_q, ex_result_d, redirect_pc_q, redirect_pc_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [1:0]  ex_ldst_q, ex_ldst_d;
  logic        load, is_jump, taken;
  execute_decode u_decode (
    .v_i      (id_v_i),
    .opcode_i (id_opcode_i),
    .funct3_i (id_funct3_i),
    .alt_i    (id_alt_i),
    .cword_o  (cword)
  );
  assign amux_sel_o    = cword.amux_sel;
  assign bmux_sel_o    = cword.bmux_sel;
  assign op_o          = cword.op;
  assign alu_alt_o     = cword.alt;
  assign alu_ldst_v_o  = cword.ldst_v;
  assign id_ready_o    = (state_q == EX_SQUASH) | ((state_q == EX_RUN) & (~ex_v_q | ex_ready_i));
  // instructions accepted during the squash cycle are wrong-path and dropped
  assign load          = id_v_i & id_ready_o & (state_q != EX_SQUASH);
  assign is_jump       = (id_opcode_i == OPC_JAL) | (id_opcode_i == OPC_JALR);
  assign taken         = load & (is_jump | ((id_opcode_i == OPC_BRANCH) & bru_result_i));
  assign ex_v_o        = ex_v_q;
  assign ex_result_o   = ex_result_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_ldst_o     = ex_ldst_q;
  assign redirect_v_o  = redirect_v_q;
  assign redirect_pc_o = redirect_pc_q;
  assign squash_o      = squash_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      EX_RUN:    state_d = (ex_v_q & ~ex_ready_i) ? EX_HOLD : EX_RUN;
      EX_HOLD:   state_d = ex_ready_i ? EX_RUN : EX_HOLD;
      EX_SQUASH: state_d = EX_RUN;
      default:   state_d = EX_RUN;
    endcase
    if (taken) state_d = EX_SQUASH;
    ex_v_d        = load | (ex_v_q & ~ex_ready_i);
    ex_result_d   = load ? (is_jump ? id_pc_i + 32'd4 : alu_result_i) : ex_result_q;
    ex_rd_d       = load ? (writes_rd(id_opcode_i) ? id_rd_i : 5'd0) : ex_rd_q;
    ex_ldst_d     = load ? ldst_of(id_opcode_i) : ex_ldst_q;
    redirect_v_d  = taken;
    squash_d      = taken;
    redirect_pc_d = taken ? ((id_opcode_i == OPC_JALR) ? {alu_result_i[31:1], 1'b0} : alu_result_i) : pc_reset_p;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= EX_RUN;
      ex_v_q        <= 1'b0;
      ex_result_q   <= '0;
      ex_rd_q       <= '0;
      ex_ldst_q     <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= pc_reset_p;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ex_v_q        <= ex_v_d;
      ex_result_q   <= ex_result_d;
      ex_rd_q       <= ex_rd_d;
      ex_ldst_q     <= ex_ldst_d;
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
      squash_q      <= squash_d;
    end
  end
endmodule

// File: tb/tb_execute_ctrl.sv
// tb_execute_ctrl: decode vector table, directed corner sequences and randomized run against a behavioural model.
module tb_execute_ctrl;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic        reset_n_i, id_v_i, id_ready_o, id_alt_i, amux_sel_o, bmux_sel_o, alu_alt_o, alu_ldst_v_o;
  logic        bru_result_i, ex_v_o, ex_ready_i, redirect_v_o, squash_o;
  logic [6:0]  id_opcode_i;
  logic [2:0]  id_funct3_i, op_o;
  logic [4:0]  id_rd_i, ex_rd_o;
  logic [31:0] id_pc_i, alu_result_i, ex_result_o, redirect_pc_o;
  logic [1:0]  ex_ldst_o;
  int passed = 0, total = 0;

  execute_ctrl dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .id_v_i(id_v_i), .id_ready_o(id_ready_o),
    .id_opcode_i(id_opcode_i), .id_funct3_i(id_funct3_i), .id_alt_i(id_alt_i), .id_rd_i(id_rd_i),
    .id_pc_i(id_pc_i), .amux_sel_o(amux_sel_o), .bmux_sel_o(bmux_sel_o), .op_o(op_o),
    .alu_alt_o(alu_alt_o), .alu_ldst_v_o(alu_ldst_v_o), .alu_result_i(alu_result_i),
    .bru_result_i(bru_result_i), .ex_v_o(ex_v_o), .ex_ready_i(ex_ready_i), .ex_result_o(ex_result_o),
    .ex_rd_o(ex_rd_o), .ex_ldst_o(ex_ldst_o), .redirect_v_o(redirect_v_o),
    .redirect_pc_o(redirect_pc_o), .squash_o(squash_o)
  );

  // model of the architecturally visible state: output register contents and the redirect pulse
  logic        m_full = 0, m_hold = 0, m_rv = 0;
  logic [31:0] m_res = 0, m_rpc = 0;
  logic [4:0]  m_rd = 0;
  logic [1:0]  m_ldst = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // {amux, bmux, op[2:0], alt, ldst_v} as the control table describes it
  function automatic logic [6:0] dec(logic v, logic [6:0] opc, logic [2:0] f3, logic alt);
    if (!v) return 7'd0;
    case (opc)
      7'h33:        return {2'b00, f3, alt, 1'b0};
      7'h13:        return {2'b01, f3, (f3 == 3'b101) & alt, 1'b0};
      7'h37, 7'h6f: return {2'b11, 3'b000, 2'b00};
      7'h17:        return {2'b01, 3'b000, 2'b00};
      7'h03, 7'h23: return {2'b01, f3, 1'b0, 1'b1};
      7'h63:        return {2'b00, f3, 2'b00};
      7'h67:        return {2'b01, 3'b000, 1'b0, 1'b1};
      default:      return 7'd0;
    endcase
  endfunction

  function automatic logic exp_ready();
    return m_rv ? 1'b1 : m_hold ? 1'b0 : (!m_full || ex_ready_i);
  endfunction

  task automatic model_step();
    logic eff, jmp, tk;
    if (!reset_n_i) begin
      m_full = 0; m_hold = 0; m_rv = 0; m_res = 0; m_rpc = 0; m_rd = 0; m_ldst = 0;
      return;
    end
    eff = id_v_i && exp_ready() && !m_rv;
    jmp = (id_opcode_i == 7'h6f) || (id_opcode_i == 7'h67);
    tk  = eff && (jmp || (id_opcode_i == 7'h63 && bru_result_i));
    m_hold = tk || m_rv ? 1'b0 : m_hold ? !ex_ready_i : (m_full && !ex_ready_i);
    if (eff) begin
      m_res  = jmp ? id_pc_i + 4 : alu_result_i;
      m_rd   = (id_opcode_i inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h6f, 7'h67}) ? id_rd_i : 5'd0;
      m_ldst = id_opcode_i == 7'h03 ? 2'b01 : id_opcode_i == 7'h23 ? 2'b10 : 2'b00;
    end
    m_full = eff || (m_full && !ex_ready_i);
    m_rpc  = tk ? (id_opcode_i == 7'h67 ? alu_result_i & ~32'd1 : alu_result_i) : 32'd0;
    m_rv   = tk;
  endtask

  task automatic drive(logic v, logic [6:0] opc, logic [2:0] f3, logic alt, logic [4:0] rd,
                       logic [31:0] pc, logic [31:0] alu, logic bru, logic rdy);
    id_v_i = v; id_opcode_i = opc; id_funct3_i = f3; id_alt_i = alt; id_rd_i = rd;
    id_pc_i = pc; alu_result_i = alu; bru_result_i = bru; ex_ready_i = rdy;
  endtask

  // compare everything against the model, advance the model across the coming edge, return at next negedge
  task automatic cyc();
    #1;
    chk("cword", {amux_sel_o, bmux_sel_o, op_o, alu_alt_o, alu_ldst_v_o}, dec(id_v_i, id_opcode_i, id_funct3_i, id_alt_i));
    chk("id_ready", id_ready_o, exp_ready());
    chk("ex_v", ex_v_o, m_full);
    chk("ex_result", ex_result_o, m_res);
    chk("ex_rd", ex_rd_o, m_rd);
    chk("ex_ldst", ex_ldst_o, m_ldst);
    chk("redirect_v", redirect_v_o, m_rv);
    chk("squash", squash_o, m_rv);
    chk("redirect_pc", redirect_pc_o, m_rpc);
    model_step();
    @(negedge clk_i);
  endtask

  typedef struct {
    logic v; logic [6:0] opc; logic [2:0] f3; logic alt; logic [6:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [6:0] opcs[10];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h0b};
    vecs[0]  = '{1, 7'h33, 3'b000, 1, 7'b00_000_1_0};
    vecs[1]  = '{1, 7'h33, 3'b111, 0, 7'b00_111_0_0};
    vecs[2]  = '{1, 7'h13, 3'b101, 1, 7'b01_101_1_0};
    vecs[3]  = '{1, 7'h13, 3'b000, 1, 7'b01_000_0_0};
    vecs[4]  = '{1, 7'h37, 3'b110, 1, 7'b11_000_0_0};
    vecs[5]  = '{1, 7'h17, 3'b011, 0, 7'b01_000_0_0};
    vecs[6]  = '{1, 7'h03, 3'b010, 0, 7'b01_010_0_1};
    vecs[7]  = '{1, 7'h23, 3'b001, 1, 7'b01_001_0_1};
    vecs[8]  = '{1, 7'h63, 3'b100, 0, 7'b00_100_0_0};
    vecs[9]  = '{1, 7'h67, 3'b000, 0, 7'b01_000_0_1};
    vecs[10] = '{1, 7'h6f, 3'b101, 1, 7'b11_000_0_0};
    vecs[11] = '{0, 7'h33, 3'b101, 1, 7'b00_000_0_0};
    reset_n_i = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    // decode is combinational, so the table is applied while held in reset
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].opc, vecs[i].f3, vecs[i].alt, 5'd3, 0, 0, 0, 1);
      #1 chk($sformatf("dec%0d", i), {amux_sel_o, bmux_sel_o, op_o, alu_alt_o, alu_ldst_v_o}, vecs[i].exp);
      @(negedge clk_i);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    chk("rst_ex_v", ex_v_o, 0); chk("rst_rpc", redirect_pc_o, 0); chk("rst_ready", id_ready_o, 1);
    reset_n_i = 1;
    // ADD
    drive(1, 7'h33, 3'b000, 0, 5'd5, 32'h10, 32'd7, 0, 1);
    #1 chk("add_amux", amux_sel_o, 0); chk("add_bmux", bmux_sel_o, 0);
    cyc();
    chk("add_v", ex_v_o, 1); chk("add_res", ex_result_o, 7); chk("add_rd", ex_rd_o, 5);
    // backpressure
    drive(1, 7'h33, 3'b000, 0, 5'd6, 32'h14, 32'd9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", id_ready_o, 0); chk("bp_res", ex_result_o, 7);
      cyc();
    end
    ex_ready_i = 1;
    cyc(); cyc();
    chk("bp_res2", ex_result_o, 9); chk("bp_rd2", ex_rd_o, 6);
    // BEQ taken, then a wrong-path instruction is swallowed
    drive(1, 7'h63, 3'b000, 0, 5'd9, 32'h80, 32'h100, 1, 1);
    cyc();
    chk("beq_rv", redirect_v_o, 1); chk("beq_pc", redirect_pc_o, 32'h100); chk("beq_sq", squash_o, 1);
    chk("beq_rd", ex_rd_o, 0);
    drive(1, 7'h33, 3'b000, 0, 5'd7, 32'h84, 32'h55, 0, 1);
    cyc();
    chk("beq_rv_off", redirect_v_o, 0); chk("beq_sq_off", squash_o, 0); chk("sq_drop", ex_v_o, 0);
    // JALR
    drive(1, 7'h67, 3'b000, 0, 5'd1, 32'h40, 32'h203, 0, 1);
    cyc();
    chk("jalr_pc", redirect_pc_o, 32'h202); chk("jalr_res", ex_result_o, 32'h44); chk("jalr_rd", ex_rd_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    // LUI, SW
    drive(1, 7'h37, 3'b000, 0, 5'd2, 32'h50, 32'h1000, 0, 1);
    #1 chk("lui_amux", amux_sel_o, 1); chk("lui_bmux", bmux_sel_o, 1); chk("lui_op", op_o, 0);
    cyc();
    drive(1, 7'h23, 3'b010, 0, 5'd4, 32'h54, 32'h2000, 0, 1);
    #1 chk("sw_ldst_v", alu_ldst_v_o, 1);
    cyc();
    chk("sw_ldst", ex_ldst_o, 2'b10); chk("sw_rd", ex_rd_o, 0);
    // reset while holding
    drive(1, 7'h33, 3'b000, 0, 5'd8, 32'h58, 32'h77, 0, 0);
    cyc(); cyc();
    reset_n_i = 0;
    cyc();
    reset_n_i = 1; id_v_i = 0;
    #1 chk("rh_v", ex_v_o, 0); chk("rh_rpc", redirect_pc_o, 0); chk("rh_ready", id_ready_o, 1);
    // randomized
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 4) != 0, opcs[$urandom_range(0, 9)], 3'($urandom), 1'($urandom),
            5'($urandom), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom, 1'($urandom), $urandom_range(0, 3) != 0);
      reset_n_i = $urandom_range(0, 39) != 0;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
